rv32i_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the rv32i core. Generates sequential fetch addresses starting at a reset vector and issues them to the instruction memory over a valid/ready request channel. In-order responses are buffered in a small prefetch FIFO and delivered to the core's `instruction` input with a valid/ready handshake. A redirect port (taken branch/jump) flushes buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/rv32i_fetch_unit_if.sv | 27 ++
 rtl/rv32i_fetch_unit.sv | 114 +++++++++++
 tb/tb_rv32i_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect and
// the instruction handoff to the core.
interface rv32i_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: credit-limited sequential requests, in-order
// prefetch FIFO of {pc, instr}, and redirect flush with stale-response drop.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32i_fetch_unit_if.master    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic          r_req_valid;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_pc  [FIFO_DEPTH];
  logic [31:0]   r_fifo_ins [FIFO_DEPTH];

  logic          w_accept;
  logic          w_held;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_cnt_next;
  logic [SW-1:0] w_need;
  logic          w_load;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_load_pc;

  assign w_accept   = r_req_valid & bus.imem_req_ready;
  assign w_held     = r_req_valid & ~bus.imem_req_ready;
  // A response with nothing tracked is a protocol violation and is ignored.
  assign w_rsp      = bus.imem_rsp_valid & (r_outstanding != '0);
  assign w_push     = w_rsp & (r_discard == '0) & ~bus.redirect_valid;
  assign w_pop      = (r_count != '0) & bus.instr_ready & ~bus.redirect_valid;
  assign w_out_next = r_outstanding + CW'(w_accept) - CW'(w_rsp);
  assign w_cnt_next = bus.redirect_valid ? '0
                    : r_count + CW'(w_push) - CW'(w_pop);
  assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Credit is judged on next-cycle occupancy so every response owns a slot.
  assign w_need     = SW'(w_cnt_next) + SW'(w_out_next);
  assign w_load     = ~w_held & (w_need < SW'(FIFO_DEPTH));
  assign w_load_pc  = bus.redirect_valid ? w_redir_pc : r_fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_valid   <= 1'b0;
      r_req_addr    <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_count       <= w_cnt_next;

      if (w_load) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= w_load_pc;
        r_fetch_pc  <= w_load_pc + 32'd4;
      end else begin
        if (w_accept) r_req_valid <= 1'b0;
        if (bus.redirect_valid) r_fetch_pc <= w_redir_pc;
      end

      // Everything still owed to the old stream, including a held request.
      if (bus.redirect_valid) begin
        r_discard <= w_out_next + CW'(w_held);
      end else if (w_rsp && r_discard != '0) begin
        r_discard <= r_discard - CW'(1);
      end

      if (bus.redirect_valid) begin
        r_rsp_pc <= w_redir_pc;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]  <= r_rsp_pc;
      r_fifo_ins[r_wr_ptr] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_req_addr;
  assign bus.instr_valid    = (r_count != '0);
  assign bus.instr          = (r_count != '0) ? r_fifo_ins[r_rd_ptr] : 32'h0;
  assign bus.instr_pc       = (r_count != '0) ? r_fifo_pc[r_rd_ptr]  : 32'h0;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Randomized bench for rv32i_fetch_unit: in-order memory model plus a
// stream-level reference of expected fetch and delivery addresses.
module tb_rv32i_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst;

  rv32i_fetch_unit_if bus ();

  rv32i_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        mem_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc, last_due, ndeliv;
  logic [31:0] exp_pc, exp_req, prev_addr;
  bit          old_pend, prev_hold;
  int          k_ready, k_iready, k_lat_min, k_lat_max, k_redir;
  bit          force_redir;
  logic [31:0] force_target;
  int          trig;
  bit          trig_hit;
  logic [31:0] trig_target;
  logic        s_req_valid, s_instr_valid;
  logic [31:0] s_req_addr, s_instr, s_instr_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic model_init();
    mem_q.delete();
    cyc       = 0;
    last_due  = 0;
    exp_pc    = RESET_PC;
    exp_req   = RESET_PC;
    old_pend  = 1'b0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    drive_idle();
    model_init();
    #1;
    check({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
    check({tag, "_req_addr"},    bus.imem_req_addr,       RESET_PC);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid),    32'd0);
    check({tag, "_instr"},       bus.instr,               32'h0);
    check({tag, "_instr_pc"},    bus.instr_pc,            32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    bit          ready, iready, redir, rsp, accept, fire;
    logic [31:0] target, rdata;
    int          lat, due, q_before;
    @(posedge clk);
    #1;
    cyc++;
    s_req_valid   = bus.imem_req_valid;
    s_req_addr    = bus.imem_req_addr;
    s_instr_valid = bus.instr_valid;
    s_instr       = bus.instr;
    s_instr_pc    = bus.instr_pc;

    if (prev_hold) begin
      check("req_hold_valid", 32'(s_req_valid), 32'd1);
      check("req_hold_addr", s_req_addr, prev_addr);
    end
    check("inflight_cap", ((mem_q.size() + int'(s_req_valid)) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);

    ready  = ($urandom_range(99) < k_ready);
    iready = ($urandom_range(99) < k_iready);
    redir  = force_redir || ($urandom_range(999) < k_redir);
    target = force_redir ? force_target : $urandom();
    force_redir = 1'b0;

    q_before = mem_q.size();
    rsp   = 1'b0;
    rdata = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp   = 1'b1;
      rdata = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end

    fire = 1'b0;
    case (trig)
      1: fire = (q_before == 2);
      2: fire = s_req_valid && !ready;
      3: fire = rsp && s_instr_valid;
      default: fire = 1'b0;
    endcase
    if (fire) begin
      if (trig == 3) iready = 1'b1;
      redir    = 1'b1;
      target   = trig_target;
      trig     = 0;
      trig_hit = 1'b1;
    end

    bus.imem_req_ready = ready;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    bus.redirect_valid = redir;
    bus.redirect_pc    = target;
    bus.instr_ready    = iready;

    accept = s_req_valid && ready;
    if (accept) begin
      if (old_pend) begin
        old_pend = 1'b0;
      end else begin
        check("req_addr", s_req_addr, exp_req);
        exp_req += 32'd4;
      end
      lat = $urandom_range(k_lat_max, k_lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{s_req_addr, due});
    end

    if (s_instr_valid && iready && !redir) begin
      check("instr_pc", s_instr_pc, exp_pc);
      check("instr", s_instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      ndeliv++;
    end

    if (redir) begin
      exp_pc   = target & 32'hFFFF_FFFC;
      exp_req  = exp_pc;
      old_pend = s_req_valid && !ready;
    end
    prev_hold = s_req_valid && !ready;
    prev_addr = s_req_addr;
  endtask

  initial begin
    int d0;
    k_ready = 100; k_iready = 100; k_lat_min = 1; k_lat_max = 1; k_redir = 0;
    force_redir = 1'b0; force_target = 32'h0;
    trig = 0; trig_hit = 1'b0; trig_target = 32'h0;
    ndeliv = 0;
    apply_reset("rst");

    // Fill: request at cycle 1, response at 2, first instruction at 3.
    step();
    check("first_req_valid", 32'(s_req_valid), 32'd1);
    check("first_req_addr", s_req_addr, RESET_PC);
    step();
    check("fill_c2_instr_valid", 32'(s_instr_valid), 32'd0);
    step();
    check("fill_c3_instr_valid", 32'(s_instr_valid), 32'd1);
    check("fill_c3_instr_pc", s_instr_pc, RESET_PC);
    repeat (12) step();

    // Core stalls: fetch must stop once the credit is used up.
    k_iready = 0;
    repeat (10) step();
    check("stall_req_valid", 32'(s_req_valid), 32'd0);
    check("stall_inflight", 32'(mem_q.size()), 32'd0);
    check("stall_instr_valid", 32'(s_instr_valid), 32'd1);

    // Redirect from a quiet state: request N+1, instruction N+3.
    k_iready = 100;
    force_redir = 1'b1; force_target = 32'h0000_0400;
    step();
    step();
    check("redir_n1_req_valid", 32'(s_req_valid), 32'd1);
    check("redir_n1_req_addr", s_req_addr, 32'h0000_0400);
    check("redir_n1_instr_valid", 32'(s_instr_valid), 32'd0);
    step();
    check("redir_n2_instr_valid", 32'(s_instr_valid), 32'd0);
    step();
    check("redir_n3_instr_valid", 32'(s_instr_valid), 32'd1);
    check("redir_n3_instr_pc", s_instr_pc, 32'h0000_0400);
    repeat (6) step();

    // Redirect with two requests outstanding.
    k_lat_min = 3; k_lat_max = 3;
    trig = 1; trig_target = 32'h0000_1003; trig_hit = 1'b0;
    for (int i = 0; i < 40 && trig != 0; i++) step();
    check("q2_redirect_hit", 32'(trig_hit), 32'd1);
    trig = 0;
    k_lat_min = 1; k_lat_max = 1;
    d0 = ndeliv;
    repeat (15) step();
    check("q2_progress", (ndeliv > d0) ? 32'd1 : 32'd0, 32'd1);

    // Redirect while a request is held by an unready memory.
    k_ready = 0;
    trig = 2; trig_target = 32'h0000_0200; trig_hit = 1'b0;
    for (int i = 0; i < 20 && trig != 0; i++) step();
    check("held_redirect_hit", 32'(trig_hit), 32'd1);
    trig = 0;
    repeat (4) step();
    k_ready = 100;
    repeat (12) step();

    // Redirect coinciding with an old response and a pop.
    trig = 3; trig_target = 32'h0000_3000; trig_hit = 1'b0;
    for (int i = 0; i < 20 && trig != 0; i++) step();
    check("rsp_pop_redirect_hit", 32'(trig_hit), 32'd1);
    trig = 0;
    step();
    check("rsp_pop_instr_valid", 32'(s_instr_valid), 32'd0);
    repeat (8) step();

    // Address wrap at the top of the address space.
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    repeat (12) step();
    check("wrap_progress", (exp_pc < 32'h100) ? 32'd1 : 32'd0, 32'd1);

    apply_reset("mid");

    k_ready = 70; k_iready = 60; k_lat_min = 1; k_lat_max = 4; k_redir = 20;
    d0 = ndeliv;
    repeat (3000) step();
    check("random_progress", ((ndeliv - d0) > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
